alu_iter_exec: RTL and testbench

ALU_ITER_EXEC -- requirements
Module: alu_iter_exec

---
 rtl/alu_iter_exec.sv | 155 +++++++++++++++
 tb/tb_alu_iter_exec.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter_exec.sv
// rtl/alu_iter_exec.sv - ALU with single-cycle logic/arithmetic ops and iterative shift-add multiply
//
// Purpose:
//   Executes one request at a time. Non-multiply ops complete on the accepting
//   edge. A multiply is run as a radix-2 shift-add sequence, one step per clock.
//   Build option ALU_MUL_EARLY_EXIT_EN ends the multiply as soon as the remaining
//   multiplier bits are all zero.
//
// Ports:
//   clk_i      in   1      clock, rising edge
//   rst_i      in   1      asynchronous active-low reset
//   valid_i    in   1      request present
//   ALUCtrl_i  in   3      000 mul, 001 sub, 010 sra, 011 and, 100 add, 101 xor, 110 sll, 111 or
//   data1_i    in   WIDTH  operand A
//   data2_i    in   WIDTH  operand B / shift amount in low log2(WIDTH) bits
//   ready_o    out  1      high while idle (request can be accepted)
//   valid_o    out  1      one-cycle pulse when data_o is updated
//   data_o     out  WIDTH  registered result
//   zero_o     out  1      data_o == 0
module alu_iter_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [2:0] OP_MUL = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_OR  = 3'b111;

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SH_W-1:0]  cnt_q, cnt_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_sum;
  logic [SH_W-1:0]  shamt;
  logic             last_step;

  assign shamt = data2_i[SH_W-1:0];

  // Single-cycle result; the mul arm is never used for data_o.
  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      OP_MUL: alu_res = '0;
      OP_SUB: alu_res = data1_i - data2_i;
      OP_SRA: alu_res = $unsigned($signed(data1_i) >>> shamt);
      OP_AND: alu_res = data1_i & data2_i;
      OP_ADD: alu_res = data1_i + data2_i;
      OP_XOR: alu_res = data1_i ^ data2_i;
      OP_SLL: alu_res = data1_i << shamt;
      OP_OR:  alu_res = data1_i | data2_i;
    endcase
  end

  // Accumulator value after the step performed on this edge.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef ALU_MUL_EARLY_EXIT_EN
  // Finish on the step that consumes the highest set multiplier bit; an
  // all-zero multiplier finishes on the first MUL edge with acc_sum == acc_q.
  assign last_step = (cnt_q == SH_W'(WIDTH - 1)) || ((mplier_q >> 1) == '0);
`else
  assign last_step = (cnt_q == SH_W'(WIDTH - 1));
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (ALUCtrl_i == OP_MUL) begin
            mcand_d  = data1_i;
            mplier_d = data2_i;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL;
          end else begin
            data_d  = alu_res;
            valid_d = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SH_W'(1);
        if (last_step) begin
          data_d  = acc_sum;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign zero_o  = (data_q == '0);

endmodule

// File: tb/tb_alu_iter_exec.sv
// tb/tb_alu_iter_exec.sv - self-checking bench for alu_iter_exec (WIDTH=32)
module tb_alu_iter_exec;

  localparam int W = 32;

`ifdef ALU_MUL_EARLY_EXIT_EN
  localparam int LAT_MUL_BY_ZERO = 2;
  localparam int LAT_MUL_BY_SIX  = 4;
`else
  localparam int LAT_MUL_BY_ZERO = 33;
  localparam int LAT_MUL_BY_SIX  = 33;
`endif

  logic         clk_i;
  logic         rst_i;
  logic         valid_i;
  logic [2:0]   ALUCtrl_i;
  logic [W-1:0] data1_i;
  logic [W-1:0] data2_i;
  logic         ready_o;
  logic         valid_o;
  logic [W-1:0] data_o;
  logic         zero_o;

  int checks;
  int failures;

  alu_iter_exec #(.WIDTH(W)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ALUCtrl_i(ALUCtrl_i),
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .zero_o   (zero_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int         lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: result from the op code's arithmetic meaning.
  function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] full;
    int sh;
    sh = int'(b % 32);
    case (op)
      3'b000: begin full = {32'd0, a} * {32'd0, b}; return full[31:0]; end
      3'b001: return a - b;
      3'b010: return $unsigned($signed(a) >>> sh);
      3'b011: return a & b;
      3'b100: return a + b;
      3'b101: return a ^ b;
      3'b110: return a << sh;
      default: return a | b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] b);
`ifdef ALU_MUL_EARLY_EXIT_EN
    int hi;
    if (op != 3'b000) return 1;
    hi = -1;
    for (int i = 0; i < 32; i++) if (b[i]) hi = i;
    return (hi < 0) ? 2 : hi + 2;
`else
    if (op != 3'b000) return 1;
    return (b === 32'hx) ? 0 : 33;
`endif
  endfunction

  // Issue one request, optionally scrambling inputs while busy, then check
  // result, latency, busy cycles, zero flag and that valid_o drops afterwards.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                        input bit scramble);
    int edges;
    int busy;
    @(negedge clk_i);
    valid_i   = 1'b1;
    ALUCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    edges = 1;
    busy  = 0;
    while (!valid_o && edges < 200) begin
      if (!ready_o) busy++;
      if (scramble) begin
        valid_i   = 1'($urandom_range(0, 1));
        ALUCtrl_i = 3'($urandom);
        data1_i   = $urandom;
        data2_i   = $urandom;
      end
      @(posedge clk_i); #1;
      edges++;
    end
    valid_i = 1'b0;
    chk({name, " result"}, 64'(data_o), 64'(exp_res));
    chk({name, " latency"}, 64'(edges), 64'(exp_lat));
    chk({name, " zero"}, 64'(zero_o), 64'(exp_res == 32'd0));
    if (op == 3'b000) chk({name, " busy cycles"}, 64'(busy), 64'(exp_lat - 1));
    @(posedge clk_i); #1;
    chk({name, " pulse width"}, 64'(valid_o), 64'd0);
  endtask

  vec_t vecs[$];

  initial begin
    int vcount;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    checks    = 0;
    failures  = 0;
    rst_i     = 1'b0;
    valid_i   = 1'b0;
    ALUCtrl_i = 3'b000;
    data1_i   = '0;
    data2_i   = '0;

    vecs.push_back('{"add wrap",   3'b100, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});
    vecs.push_back('{"sub neg",    3'b001, 32'd5,        32'd7,        32'hFFFFFFFE, 1});
    vecs.push_back('{"sra sign",   3'b010, 32'h80000000, 32'd4,        32'hF8000000, 1});
    vecs.push_back('{"sll 31",     3'b110, 32'h00000001, 32'd31,       32'h80000000, 1});
    vecs.push_back('{"sll by 0",   3'b110, 32'h12345678, 32'h00000020, 32'h12345678, 1});
    vecs.push_back('{"sra by 0",   3'b010, 32'h87654321, 32'h00000000, 32'h87654321, 1});
    vecs.push_back('{"sra pos",    3'b010, 32'h70000000, 32'd28,       32'h00000007, 1});
    vecs.push_back('{"and",        3'b011, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1});
    vecs.push_back('{"xor",        3'b101, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1});
    vecs.push_back('{"or",         3'b111, 32'hF0F0F0F0, 32'h0F000000, 32'hFFF0F0F0, 1});
    vecs.push_back('{"mul ones",   3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33});
    vecs.push_back('{"mul by 0",   3'b000, 32'd12345,    32'd0,        32'd0,        LAT_MUL_BY_ZERO});
    vecs.push_back('{"mul 7x6",    3'b000, 32'd7,        32'd6,        32'd42,       LAT_MUL_BY_SIX});
    vecs.push_back('{"mul msb",    3'b000, 32'd3,        32'h80000000, 32'h80000000, 33});

    // Reset state
    @(posedge clk_i); #1;
    chk("reset ready", 64'(ready_o), 64'd1);
    chk("reset valid", 64'(valid_o), 64'd0);
    chk("reset data",  64'(data_o),  64'd0);
    chk("reset zero",  64'(zero_o),  64'd1);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Directed table
    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
             vecs[i].op == 3'b000);

    // Back-to-back single-cycle ops
    @(negedge clk_i);
    valid_i = 1'b1; ALUCtrl_i = 3'b100; data1_i = 32'hFFFFFFFF; data2_i = 32'd1;
    @(posedge clk_i); #1;
    chk("b2b first valid", 64'(valid_o), 64'd1);
    chk("b2b first data",  64'(data_o),  64'd0);
    chk("b2b first zero",  64'(zero_o),  64'd1);
    ALUCtrl_i = 3'b001; data1_i = 32'd5; data2_i = 32'd7;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    chk("b2b second valid", 64'(valid_o), 64'd1);
    chk("b2b second data",  64'(data_o),  64'hFFFFFFFE);
    chk("b2b second zero",  64'(zero_o),  64'd0);
    @(posedge clk_i); #1;
    chk("b2b idle valid", 64'(valid_o), 64'd0);

    // Reset in the middle of a multiply
    run_op("pre-reset add", 3'b100, 32'd5, 32'd6, 32'd11, 1, 1'b0);
    @(negedge clk_i);
    valid_i = 1'b1; ALUCtrl_i = 3'b000; data1_i = 32'hFFFFFFFF; data2_i = 32'hFFFFFFFF;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk_i); #1;
    end
    chk("mid-mul busy", 64'(ready_o), 64'd0);
    rst_i = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("rst valid", 64'(valid_o), 64'd0);
      chk("rst data",  64'(data_o),  64'd0);
      chk("rst ready", 64'(ready_o), 64'd1);
      chk("rst zero",  64'(zero_o),  64'd1);
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    vcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk_i); #1;
      if (valid_o) vcount++;
    end
    chk("no stale pulse", 64'(vcount), 64'd0);
    run_op("post-reset mul", 3'b000, 32'd9, 32'd9, 32'd81, model_lat(3'b000, 32'd9), 1'b1);

    // Randomized against the reference model
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = rb >> $urandom_range(0, 31);
        2: ra = 32'hFFFFFFFF;
        default: ;
      endcase
      run_op($sformatf("rand%0d op%0d", n, rop), rop, ra, rb, model_res(rop, ra, rb),
             model_lat(rop, rb), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
